// File: rtl/caesar_decoder.sv
// -----------------------------------------------------------------------------
// caesar_decoder
//
// Streaming Caesar-cipher decryptor. ASCII ciphertext arrives on a valid/ready
// input, letters are shifted back by the current key (other bytes pass through
// unchanged), and the plaintext is buffered in a small FIFO that drives a
// valid/ready output toward the display path.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset (synchronous release)
//   key_load      in   strobe: capture key_in (reduced mod 26) into key register
//   key_in        in   [4:0] shift amount 0..31
//   in_valid      in   ciphertext character present
//   in_ready      out  FIFO not full; depends on FIFO state only
//   in_char       in   [7:0] ASCII ciphertext
//   out_valid     out  FIFO not empty
//   out_ready     in   downstream consumes the head this cycle
//   out_char      out  [7:0] plaintext at FIFO head
//   key_cur       out  [4:0] effective key 0..25
//   letter_count  out  [CNT_W-1:0] letters decoded since reset, saturating
// -----------------------------------------------------------------------------
module caesar_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             key_load,
  input  logic [4:0]       key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic [4:0]       key_cur,
  output logic [CNT_W-1:0] letter_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Last character popped; shown on out_char while the FIFO is empty so the
  // output keeps its last value instead of exposing a stale slot.
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       mem_q [DEPTH];

  logic             full, empty, push, pop;
  logic             is_upper, is_lower, is_letter;
  logic [7:0]       base, offset;
  logic [5:0]       idx, plain_idx;
  logic [7:0]       dec_char;
  logic [7:0]       head_char;

  // ---------------------------------------------------------------------------
  // Letter decode, applied on the write side with the key in force this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
    is_lower  = (in_char >= 8'h61) && (in_char <= 8'h7A);
    is_letter = is_upper || is_lower;
    base      = is_upper ? 8'h41 : 8'h61;
    offset    = in_char - base;
    idx       = offset[5:0];
    // Six bits keep idx+26 from overflowing before the subtraction.
    if (idx >= {1'b0, key_q}) begin
      plain_idx = idx - {1'b0, key_q};
    end else begin
      plain_idx = idx + 6'd26 - {1'b0, key_q};
    end
    dec_char = is_letter ? (base + {2'b00, plain_idx}) : in_char;
  end

  // ---------------------------------------------------------------------------
  // FIFO status and next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && !full;
    pop       = out_ready && !empty;
    head_char = mem_q[rd_ptr_q[AW-1:0]];

    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};

    key_d = key_q;
    if (key_load) begin
      key_d = (key_in >= 5'd26) ? (key_in - 5'd26) : key_in;
    end

    cnt_d = cnt_q;
    if (push && is_letter && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    hold_d = pop ? head_char : hold_q;

    out_char     = empty ? hold_q : head_char;
    key_cur      = key_q;
    letter_count = cnt_q;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  // Storage needs no reset: pointer reset alone discards the contents.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= dec_char;
    end
  end

endmodule

// File: tb/tb_caesar_decoder.sv
module tb_caesar_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_load = 1'b0;
  logic [4:0]  key_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_char;
  logic [4:0]  key_cur;
  logic [15:0] letter_count;

  logic [7:0]  exp_char = '0;
  logic [7:0]  sb_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  caesar_decoder #(.DEPTH(4), .CNT_W(16)) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .key_load    (key_load),
    .key_in      (key_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_char    (out_char),
    .key_cur     (key_cur),
    .letter_count(letter_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Stimulus side of the scoreboard: every accepted character queues its
  // hand-computed plaintext.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb_q.push_back(exp_char);
      $display("accept in=0x%02h expect=0x%02h", in_char, exp_char);
    end
  end

  // Monitor: compares the FIFO head whenever a pop handshake occurs.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got 0x%02h, required no output", out_char);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        $display("pop   out=0x%02h expect=0x%02h", out_char, e);
        check("out_char", {24'd0, out_char}, {24'd0, e});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [7:0] c, input logic [7:0] e);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_valid = 1'b1;
    in_char  = c;
    exp_char = e;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else begin
        n++;
        if (n > 20) begin
          total_cnt++;
          $display("FAIL send_timeout: char 0x%02h got no in_ready, required accept", c);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [4:0] k);
    key_load = 1'b1;
    key_in   = k;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    bit done;
    n = 0;
    done = 0;
    out_ready = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) done = 1;
      else begin
        n++;
        if (n > 30) begin
          total_cnt++;
          $display("FAIL drain_timeout: %0d entries pending, required 0", sb_q.size());
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_key_cur", {27'd0, key_cur}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_char", {24'd0, out_char}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_letter_count", {16'd0, letter_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Key 3, "DAHOOR" -> "AXELLO"; verify one-cycle latency with no bypass
    load_key(5'd3);
    check("key_cur_3", {27'd0, key_cur}, 32'd3);
    out_ready = 1'b1;
    in_valid = 1'b1; in_char = "D"; exp_char = "A";
    @(negedge clk);
    check("first_in_ready", {31'd0, in_ready}, 32'd1);
    check("no_bypass_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_char = "A"; exp_char = "X";
    @(negedge clk);
    check("latency1_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send("H", "E");
    send("O", "L");
    send("O", "L");
    send("R", "O");
    drain();
    check("count_after_dahoor", {16'd0, letter_count}, 32'd6);
    check("key_cur_still_3", {27'd0, key_cur}, 32'd3);

    // Lower case, wrap, non-letters and range boundaries
    send("a", "x");
    send("c", "z");
    send(" ", " ");
    send("!", "!");
    send("Z", "W");
    send(8'h40, 8'h40);
    send(8'h5B, 8'h5B);
    send(8'h60, 8'h60);
    send(8'h7B, 8'h7B);
    send(8'h80, 8'h80);
    send(8'hC1, 8'hC1);
    drain();
    check("count_letters_only", {16'd0, letter_count}, 32'd9);

    // Key reduction mod 26 and old key on load cycle
    load_key(5'd29);
    check("key_29_to_3", {27'd0, key_cur}, 32'd3);
    load_key(5'd26);
    check("key_26_to_0", {27'd0, key_cur}, 32'd0);
    send("Q", "Q");
    load_key(5'd1);
    key_load = 1'b1; key_in = 5'd5;
    in_valid = 1'b1; in_char = "D"; exp_char = "C";
    @(negedge clk);
    check("keyload_cycle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    key_load = 1'b0; in_valid = 1'b0;
    check("key_cur_5", {27'd0, key_cur}, 32'd5);
    send("F", "A");
    send("a", "v");
    drain();
    check("count_after_keys", {16'd0, letter_count}, 32'd13);

    // Backpressure: fill, hold 5th, single pop, order preserved
    out_ready = 1'b0;
    send("E", "Z");
    send("F", "A");
    send("G", "B");
    send("H", "C");
    in_valid = 1'b1; in_char = "I"; exp_char = "D";
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_head", {24'd0, out_char}, {24'd0, 8'h5A});
    @(posedge clk); #1;
    @(negedge clk);
    check("full_in_ready_hold", {31'd0, in_ready}, 32'd0);
    check("full_head_stable", {24'd0, out_char}, {24'd0, 8'h5A});
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    check("after_pop_head", {24'd0, out_char}, {24'd0, 8'h41});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("count_after_full", {16'd0, letter_count}, 32'd18);

    // Steady push+pop at occupancy 2 for 10 cycles (pointers wrap)
    out_ready = 1'b0;
    send("1", "1");
    send("2", "2");
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_char  = 8'h33 + 8'(i);
      exp_char = 8'h33 + 8'(i);
      @(negedge clk);
      check("steady_in_ready", {31'd0, in_ready}, 32'd1);
      check("steady_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("count_after_steady", {16'd0, letter_count}, 32'd18);

    // Asynchronous reset with 3 entries buffered
    out_ready = 1'b0;
    send("x", "s");
    send("y", "t");
    send("z", "u");
    @(negedge clk);
    check("buffered_out_valid", {31'd0, out_valid}, 32'd1);
    check("buffered_count", {16'd0, letter_count}, 32'd21);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_count", {16'd0, letter_count}, 32'd0);
    check("async_rst_key", {27'd0, key_cur}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_key_cur", {27'd0, key_cur}, 32'd0);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
